fetch_stage: RTL and testbench

Instruction fetch stage for the 16-bit pipelined processor, sitting directly upstream of decode/register-read. It owns the program counter, drives the word-addressed instruction memory, and buffers fetched instructions with their PC in a small prefetch queue. The queue feeds decode through a valid/ready handshake. Execute redirects it on taken branches, FOR loops, RET and any other non-sequential control flow.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/fetch_queue.sv | 107 ++++++++++
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//
// Shared definitions for the 16-bit pipelined processor front end.
//
// Contents:
//   - J-type opcode and function-field constants used by fetch predecode.
//   - fetch_entry_t: one prefetch-queue entry {instr, pc, predicted}.
//   - Small field-extraction helpers for the instruction word.
//
// J-type instruction layout:
//   [15:12] opcode   [11:3] 9-bit target   [2:0] func
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN = 16;

    // Opcode / function encodings
    localparam logic [3:0] OP_JTYPE = 4'b0001;

    localparam logic [2:0] FN_JMP  = 3'b000;
    localparam logic [2:0] FN_CALL = 3'b001;
    localparam logic [2:0] FN_RET  = 3'b010;

    // One prefetch-queue entry
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            predicted;
    } fetch_entry_t;

    function automatic logic [3:0] instr_opcode(input logic [XLEN-1:0] instr);
        return instr[15:12];
    endfunction

    function automatic logic [2:0] instr_func(input logic [XLEN-1:0] instr);
        return instr[2:0];
    endfunction

    function automatic logic [8:0] instr_jtarget(input logic [XLEN-1:0] instr);
        return instr[11:3];
    endfunction

    // Direct jumps whose target is fully encoded in the word (JMP, CALL).
    // RET depends on the return register, so it is left to execute.
    function automatic logic is_direct_jump(input logic [XLEN-1:0] instr);
        return (instr_opcode(instr) == OP_JTYPE) &&
               ((instr_func(instr) == FN_JMP) || (instr_func(instr) == FN_CALL));
    endfunction

endpackage : cpu_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Small circular FIFO of fetch_entry_t buffering fetched instructions between
// the PC/imem side of the fetch stage and decode.
//
// Parameters:
//   DEPTH   number of entries; power of two, minimum 2.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous active-low reset (empties queue, zeroes storage)
//   flush_i        empty the queue and return both pointers to 0 (wins over push/pop)
//   push_i         write push_entry_i at the write pointer
//   pop_i          retire the head entry
//   push_entry_i   entry to write
//   head_o         entry at the read pointer (registered storage, no bypass)
//   count_o        number of valid entries
//
// Push and pop in the same cycle are allowed when full: the slot being
// written is the one being retired, and the head is read before the edge.
// -----------------------------------------------------------------------------
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  fetch_entry_t     push_entry_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic pop_eff;
    logic push_eff;

    // Guard against popping an empty queue or pushing into a full one that
    // is not simultaneously draining; the stage never asks for either.
    assign pop_eff  = pop_i  && (count_q != '0);
    assign push_eff = push_i && ((count_q < CNT_W'(DEPTH)) || pop_eff);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

            unique case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage is reset as well, so the head outputs read a
    // defined all-zero entry out of reset; this keeps the array in flops
    // rather than a RAM macro, which is fine at this depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_eff && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_queue

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage of the 16-bit pipelined processor. Owns the PC,
// drives the word-addressed instruction memory and buffers fetched words with
// their address in a prefetch queue that feeds decode via valid/ready.
//
// Parameters:
//   DEPTH      prefetch queue entries (power of two, >= 2), default 2
//   RESET_PC   PC loaded on reset, default 16'h0000
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   imem_addr       instruction memory word address (the PC register)
//   imem_rdata      instruction word, combinational read of imem_addr
//   redirect_valid  execute demands a control-flow change this cycle
//   redirect_pc     new fetch address, taken when redirect_valid=1
//   id_valid        head entry presented to decode
//   id_ready        decode accepts the head entry
//   id_instr        head instruction word
//   id_pc           head entry address
//   id_pc_plus_1    id_pc + 1 (mod 2^16)
//   id_predicted    head entry was already redirected by predecode
//
// Compile-time option:
//   FETCH_PREDECODE_EN  when defined, JMP/CALL words are predecoded at fetch
//                       and the PC follows the encoded target immediately.
//                       When undefined, fetch is purely sequential and
//                       id_predicted is constant 0.
// -----------------------------------------------------------------------------
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,

    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,

    output logic        id_valid,
    input  logic        id_ready,
    output logic [15:0] id_instr,
    output logic [15:0] id_pc,
    output logic [15:0] id_pc_plus_1,
    output logic        id_predicted
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      pc_plus_1;
    logic [15:0]      fetch_next_pc;
    logic             fetch_predicted;
    logic             fetch_en;
    logic             pop;
    logic             queue_has_room;
    logic [CNT_W-1:0] count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    // -------------------------------------------------------------------------
    // Handshake and fetch enable
    // -------------------------------------------------------------------------
    // A redirect cycle forces id_valid low, so no handshake can complete
    // while the queue is being flushed.
    assign id_valid       = (count != '0) && !redirect_valid;
    assign pop            = id_valid && id_ready;
    assign queue_has_room = (count < CNT_W'(DEPTH));
    // A full queue still accepts a push when decode drains the head the same
    // cycle, which is what sustains one instruction per cycle.
    assign fetch_en       = !redirect_valid && (queue_has_room || pop);

    // -------------------------------------------------------------------------
    // Next sequential / predicted fetch address
    // -------------------------------------------------------------------------
    assign pc_plus_1 = pc_q + 16'd1;

`ifdef FETCH_PREDECODE_EN
    // The 9-bit target replaces the low bits of PC+1, i.e. a jump within the
    // 512-word region of the following instruction.
    assign fetch_predicted = is_direct_jump(imem_rdata);
    assign fetch_next_pc   = fetch_predicted ? {pc_plus_1[15:9], instr_jtarget(imem_rdata)}
                                             : pc_plus_1;
`else
    assign fetch_predicted = 1'b0;
    assign fetch_next_pc   = pc_plus_1;
`endif

    // -------------------------------------------------------------------------
    // PC register
    // -------------------------------------------------------------------------
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (fetch_en) begin
            pc_d = fetch_next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    // -------------------------------------------------------------------------
    // Prefetch queue
    // -------------------------------------------------------------------------
    assign push_entry = '{instr: imem_rdata, pc: pc_q, predicted: fetch_predicted};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .push_i       (fetch_en),
        .pop_i        (pop),
        .push_entry_i (push_entry),
        .head_o       (head),
        .count_o      (count)
    );

    // Decode-side outputs come straight from queue storage; there is no
    // combinational path from imem_rdata to any id_* output.
    assign id_instr     = head.instr;
    assign id_pc        = head.pc;
    assign id_pc_plus_1 = head.pc + 16'd1;
    // Without predecode the stored flag is only ever written with 0, so this
    // output is constant 0.
    assign id_predicted = head.predicted;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage (DEPTH=2, RESET_PC=0). Instruction
// memory is modelled as imem_addr ^ 16'hA5A5, with an optional JMP 7 planted
// at address 5. Directed scenarios cover reset, sequential fetch,
// backpressure, redirect, wrap-around, predecode and asynchronous reset; a
// randomized run is checked against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int          DEPTH    = 2;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] JMP7     = 16'b0001_000000111_000;
`ifdef FETCH_PREDECODE_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [15:0] id_pc_plus_1;
    logic        id_predicted;

    bit plant_jmp;
    int checks;
    int failures;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        bit          pred;
    } exp_entry_t;

    always #5 clk = ~clk;

    assign imem_rdata = (plant_jmp && imem_addr == 16'd5) ? JMP7 : (imem_addr ^ 16'hA5A5);

    fetch_stage #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus_1   (id_pc_plus_1),
        .id_predicted   (id_predicted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] addr);
        return (plant_jmp && addr == 16'd5) ? JMP7 : (addr ^ 16'hA5A5);
    endfunction

    // Hold reset for two cycles and release it on a falling edge.
    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        id_ready       = ready;
        plant_jmp      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        checks++; if (id_instr !== 16'h0000) begin failures++; $display("FAIL reset_instr: got %h want 0000", id_instr); end
        checks++; if (id_pc !== 16'h0000) begin failures++; $display("FAIL reset_pc: got %h want 0000", id_pc); end
        checks++; if (id_pc_plus_1 !== 16'h0001) begin failures++; $display("FAIL reset_pc_plus_1: got %h want 0001", id_pc_plus_1); end
        checks++; if (id_predicted !== 1'b0) begin failures++; $display("FAIL reset_predicted: got %b want 0", id_predicted); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [15:0] e;
        do_reset(1'b1);
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL seq_first_valid: got %b want 0", id_valid); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            e = 16'(i);
            checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL seq_valid[%0d]: got %b want 1", i, id_valid); end
            checks++; if (id_pc !== e) begin failures++; $display("FAIL seq_pc[%0d]: got %h want %h", i, id_pc, e); end
            checks++; if (id_instr !== (e ^ 16'hA5A5)) begin failures++; $display("FAIL seq_instr[%0d]: got %h want %h", i, id_instr, e ^ 16'hA5A5); end
            checks++; if (id_pc_plus_1 !== e + 16'd1) begin failures++; $display("FAIL seq_pc_plus_1[%0d]: got %h want %h", i, id_pc_plus_1, e + 16'd1); end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk); #1;
            checks++; if (id_pc !== 16'h0000) begin failures++; $display("FAIL bp_hold_pc[%0d]: got %h want 0000", c, id_pc); end
            checks++; if (imem_addr !== ((c == 1) ? 16'd1 : 16'd2)) begin failures++; $display("FAIL bp_imem_addr[%0d]: got %h want %h", c, imem_addr, (c == 1) ? 16'd1 : 16'd2); end
        end
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL bp_valid: got %b want 1", id_valid); end
        id_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            checks++; if (id_pc !== 16'(i)) begin failures++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, id_pc, 16'(i)); end
            checks++; if (id_instr !== (16'(i) ^ 16'hA5A5)) begin failures++; $display("FAIL bp_drain_instr[%0d]: got %h want %h", i, id_instr, 16'(i) ^ 16'hA5A5); end
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0020;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_n: got %b want 0", id_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_n1: got %b want 0", id_valid); end
        checks++; if (imem_addr !== 16'h0020) begin failures++; $display("FAIL redir_imem_addr: got %h want 0020", imem_addr); end
        @(negedge clk); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0020) begin failures++; $display("FAIL redir_pc_n2: got valid=%b pc=%h want valid=1 pc=0020", id_valid, id_pc); end
        @(negedge clk); #1;
        checks++; if (id_pc !== 16'h0021) begin failures++; $display("FAIL redir_pc_n3: got %h want 0021", id_pc); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFF;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_imem_addr: got %h want ffff", imem_addr); end
        @(negedge clk); #1;
        checks++; if (id_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_pc0: got %h want ffff", id_pc); end
        checks++; if (id_pc_plus_1 !== 16'h0000) begin failures++; $display("FAIL wrap_pc_plus_1: got %h want 0000", id_pc_plus_1); end
        @(negedge clk); #1;
        checks++; if (id_pc !== 16'h0000) begin failures++; $display("FAIL wrap_pc1: got %h want 0000", id_pc); end
    endtask

    task automatic test_predecode();
        logic [15:0] exp_next;
        logic        exp_pred;
        exp_next = PRED_EN ? 16'd7 : 16'd6;
        exp_pred = PRED_EN;
        plant_jmp = 1'b1;
        @(negedge clk);
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'd5;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (imem_addr !== 16'd5) begin failures++; $display("FAIL pd_imem_addr: got %h want 0005", imem_addr); end
        @(negedge clk); #1;
        checks++; if (id_pc !== 16'd5 || id_instr !== JMP7) begin failures++; $display("FAIL pd_entry: got pc=%h instr=%h want pc=0005 instr=%h", id_pc, id_instr, JMP7); end
        checks++; if (id_predicted !== exp_pred) begin failures++; $display("FAIL pd_predicted: got %b want %b", id_predicted, exp_pred); end
        @(negedge clk); #1;
        checks++; if (id_pc !== exp_next) begin failures++; $display("FAIL pd_next_pc: got %h want %h", id_pc, exp_next); end
        checks++; if (id_predicted !== 1'b0) begin failures++; $display("FAIL pd_next_predicted: got %b want 0", id_predicted); end
        plant_jmp = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 16'h0040 || imem_addr !== 16'h0042) begin failures++; $display("FAIL arst_full: got valid=%b pc=%h addr=%h want 1/0040/0042", id_valid, id_pc, imem_addr); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL arst_valid: got %b want 0", id_valid); end
        checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL arst_imem_addr: got %h want %h", imem_addr, RESET_PC); end
        @(negedge clk);
        rst      = 1'b1;
        id_ready = 1'b1;
        @(negedge clk); #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== RESET_PC) begin failures++; $display("FAIL arst_release: got valid=%b pc=%h want 1/%h", id_valid, id_pc, RESET_PC); end
    endtask

    task automatic test_random();
        exp_entry_t  mq[$];
        exp_entry_t  e;
        logic [15:0] mpc;
        logic [15:0] w;
        logic [15:0] inc;
        bit          exp_valid;
        bit          do_pop;
        bit          room;
        int unsigned sel;
        do_reset(1'b1);
        mpc = RESET_PC;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            id_ready       = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 15) == 0);
            sel            = $urandom_range(0, 2);
            redirect_pc    = (sel == 0) ? {4'hB, 12'($urandom)} :
                             (sel == 1) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
            #1;
            exp_valid = (mq.size() != 0) && !redirect_valid;
            checks++; if (id_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, id_valid, exp_valid); end
            checks++; if (imem_addr !== mpc) begin failures++; $display("FAIL rnd_imem_addr[%0d]: got %h want %h", cyc, imem_addr, mpc); end
            if (exp_valid) begin
                e = mq[0];
                checks++;
                if (id_pc !== e.pc || id_instr !== e.instr || id_pc_plus_1 !== e.pc + 16'd1 || id_predicted !== e.pred) begin
                    failures++;
                    $display("FAIL rnd_head[%0d]: got pc=%h instr=%h pc1=%h pred=%b want pc=%h instr=%h pc1=%h pred=%b",
                             cyc, id_pc, id_instr, id_pc_plus_1, id_predicted, e.pc, e.instr, e.pc + 16'd1, e.pred);
                end
            end
            // Reference model step: redirect flushes; otherwise pop, then fetch if a slot frees.
            if (redirect_valid) begin
                mq.delete();
                mpc = redirect_pc;
            end else begin
                do_pop = exp_valid && id_ready;
                room   = (mq.size() < DEPTH) || do_pop;
                if (do_pop) void'(mq.pop_front());
                if (room) begin
                    w      = mem_word(mpc);
                    inc    = mpc + 16'd1;
                    e.pc   = mpc;
                    e.instr = w;
                    e.pred = PRED_EN && (w[15:12] == 4'h1) && (w[2:0] <= 3'd1);
                    mq.push_back(e);
                    mpc = e.pred ? ((inc & 16'hFE00) | ((w >> 3) & 16'h01FF)) : inc;
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        id_ready       = 1'b0;
        plant_jmp      = 1'b0;

        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_full();
        test_wrap();
        test_predecode();
        test_async_reset();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
